// File: rtl/pit_bus_if.sv
// IPIF slave bus bundle for the multi-channel interval timer: CE-decoded
// register accesses in, same-cycle data/ack/error out.
interface pit_bus_if #(
  parameter int NUM_REGS = 13
);
  logic [31:0]         Bus2IP_Data;
  logic [3:0]          Bus2IP_BE;
  logic [NUM_REGS-1:0] Bus2IP_RdCE;
  logic [NUM_REGS-1:0] Bus2IP_WrCE;
  logic [31:0]         IP2Bus_Data;
  logic                IP2Bus_RdAck;
  logic                IP2Bus_WrAck;
  logic                IP2Bus_Error;

  modport master (
    output Bus2IP_Data, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE,
    input  IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );

  modport slave (
    input  Bus2IP_Data, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE,
    output IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );
endinterface

// File: rtl/pit_multichannel.sv
// Multi-channel programmable interval timer: NUM_CH down-counters sharing one
// prescaler, sticky expiry status, masked-OR interrupt, IPIF register access.
module pit_multichannel #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 32,
  parameter int PRESCALE = 1
) (
  input  logic     Bus2IP_Clk,
  input  logic     Bus2IP_Reset,
  pit_bus_if.slave bus,
  output logic     IP_Interupt
);
  localparam int NUM_REGS = 3*NUM_CH+1;
  localparam int PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [NUM_REGS-1:0] rd_sel, wr_sel;
  logic                wr_count_hit, wr_ok, tick;
  logic [PS_W-1:0]     ps_q, ps_d;
  logic [2:0]          ctrl_q [NUM_CH];
  logic [2:0]          ctrl_d [NUM_CH];
  logic [CNT_W-1:0]    period_q [NUM_CH];
  logic [CNT_W-1:0]    period_d [NUM_CH];
  logic [CNT_W-1:0]    count_q [NUM_CH];
  logic [CNT_W-1:0]    count_d [NUM_CH];
  logic [NUM_CH-1:0]   status_q, status_d, expire, w1c, irq_en;
  logic                irq_q, irq_d;
  logic [31:0]         merged, rdata;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return res;
  endfunction

  // CE vectors are MSB-first; flip so bit k addresses register k.
  always_comb begin
    rd_sel       = '0;
    wr_sel       = '0;
    wr_count_hit = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      rd_sel[k] = bus.Bus2IP_RdCE[NUM_REGS-1-k];
      wr_sel[k] = bus.Bus2IP_WrCE[NUM_REGS-1-k];
    end
    for (int c = 0; c < NUM_CH; c++)
      wr_count_hit = wr_count_hit | wr_sel[3+3*c];
    wr_ok = $onehot(bus.Bus2IP_WrCE) && !wr_count_hit;
  end

  always_comb begin
    tick     = (ps_q == PS_W'(PRESCALE-1));
    ps_d     = tick ? '0 : ps_q + PS_W'(1);
    ctrl_d   = ctrl_q;
    period_d = period_q;
    count_d  = count_q;
    expire   = '0;
    merged   = '0;
    irq_en   = '0;
    w1c      = (wr_ok && wr_sel[0] && bus.Bus2IP_BE[0]) ? bus.Bus2IP_Data[NUM_CH-1:0] : '0;
    for (int c = 0; c < NUM_CH; c++) begin
      irq_en[c] = ctrl_q[c][1];
      if (wr_ok && wr_sel[1+3*c] && bus.Bus2IP_BE[0])
        ctrl_d[c] = bus.Bus2IP_Data[2:0];
      if (wr_ok && wr_sel[2+3*c]) begin
        merged      = be_merge(32'(period_q[c]), bus.Bus2IP_Data, bus.Bus2IP_BE);
        period_d[c] = merged[CNT_W-1:0];
      end
      // Enable edges written by software take priority over counting.
      if (!ctrl_q[c][0] && ctrl_d[c][0]) begin
        count_d[c] = period_d[c];
      end else if (ctrl_q[c][0] && !ctrl_d[c][0]) begin
        count_d[c] = '0;
      end else if (ctrl_q[c][0] && tick) begin
        if (count_q[c] > CNT_W'(1)) begin
          count_d[c] = count_q[c] - CNT_W'(1);
        end else if (count_q[c] == CNT_W'(1)) begin
          expire[c] = 1'b1;
          if (ctrl_q[c][2]) begin
            count_d[c] = period_d[c];
          end else begin
            count_d[c]   = '0;
            ctrl_d[c][0] = 1'b0;
          end
        end
      end
    end
    // A fresh expiry beats a simultaneous write-1-to-clear.
    status_d = (status_q & ~w1c) | expire;
    irq_d    = |(status_q & irq_en);
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      ps_q     <= '0;
      status_q <= '0;
      irq_q    <= 1'b0;
      ctrl_q   <= '{default: '0};
      period_q <= '{default: '0};
      count_q  <= '{default: '0};
    end else begin
      ps_q     <= ps_d;
      status_q <= status_d;
      irq_q    <= irq_d;
      ctrl_q   <= ctrl_d;
      period_q <= period_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    rdata = rd_sel[0] ? 32'(status_q) : 32'h0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_sel[1+3*c]) rdata = rdata | 32'(ctrl_q[c]);
      if (rd_sel[2+3*c]) rdata = rdata | 32'(period_q[c]);
      if (rd_sel[3+3*c]) rdata = rdata | 32'(count_q[c]);
    end
  end

  assign bus.IP2Bus_Data  = rdata;
  assign bus.IP2Bus_RdAck = |bus.Bus2IP_RdCE;
  assign bus.IP2Bus_WrAck = |bus.Bus2IP_WrCE;
  assign bus.IP2Bus_Error = (|bus.Bus2IP_RdCE && !$onehot(bus.Bus2IP_RdCE)) ||
                            (|bus.Bus2IP_WrCE && (!$onehot(bus.Bus2IP_WrCE) || wr_count_hit));
  assign IP_Interupt      = irq_q;
endmodule
